// File: rtl/periph_bus_arbiter_if.sv
// Bus bundle for the peripheral arbiter: two requester ports plus the shared slave bus.
// "master" is the arbiter's view; "slave" is the environment (requesters and slaves).
`timescale 1ns/1ps
interface periph_bus_arbiter_if #(
    parameter int NSLV = 4
);
    logic              m0_req;
    logic              m1_req;
    logic              m0_wr;
    logic              m1_wr;
    logic [31:0]       m0_addr;
    logic [31:0]       m1_addr;
    logic [31:0]       m0_wdata;
    logic [31:0]       m1_wdata;
    logic              m0_ack;
    logic              m1_ack;
    logic              m0_err;
    logic              m1_err;
    logic [31:0]       m0_rdata;
    logic [31:0]       m1_rdata;
    logic [NSLV-1:0]   s_cs;
    logic              s_wr;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [NSLV*32-1:0] s_rdata;

    modport master (
        input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata, s_cs, s_wr, s_addr, s_wdata
    );

    modport slave (
        output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata, s_cs, s_wr, s_addr, s_wdata
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral register bus with one-hot slave decode,
// a fixed IDLE -> ACCESS -> DONE handshake, registered read data and a decode-error flag.
`timescale 1ns/1ps
module periph_bus_arbiter #(
    parameter int          NSLV = 4,
    parameter logic [31:0] BASE = 32'h4000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    periph_bus_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic [NSLV-1:0]   cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [1:0][31:0]  rdata_q, rdata_d;

    logic              sel1;
    logic              req_wr;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [19:0]       page;
    logic [NSLV-1:0]   dec;
    logic [31:0]       slv_rd;

    // Winner selection and decode of the winner's address; last_q=1 favours master 0 on a tie.
    always_comb begin
        sel1      = bus.m1_req && (!bus.m0_req || !last_q);
        req_wr    = sel1 ? bus.m1_wr    : bus.m0_wr;
        req_addr  = sel1 ? bus.m1_addr  : bus.m0_addr;
        req_wdata = sel1 ? bus.m1_wdata : bus.m0_wdata;
        page      = req_addr[31:12] - BASE[31:12];
        dec       = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (page == 20'(k)) dec[k] = 1'b1;
        end
        slv_rd = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (cs_q[k]) slv_rd = bus.s_rdata[k*32 +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        cs_d    = '0;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        ack_d   = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    last_d = sel1;
                    win_d  = sel1;
                    cs_d   = dec;
                    if (|dec) begin
                        wr_d    = req_wr;
                        addr_d  = {20'b0, req_addr[11:0]};
                        wdata_d = req_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ack_d[win_q] = 1'b1;
                err_d[win_q] = ~|cs_q;
                // An empty select means the latched address missed every window.
                if (~|cs_q)     rdata_d[win_q] = '0;
                else if (!wr_q) rdata_d[win_q] = slv_rd;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            cs_q    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m1_rdata = rdata_q[1];
    assign bus.s_cs     = cs_q;
    assign bus.s_wr     = wr_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: vector table for single-master accesses plus
// hand-written sequences for reset, tie-break, fairness and reset during an access.
`timescale 1ns/1ps
module tb_periph_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    periph_bus_arbiter_if #(.NSLV(4)) bus ();

    periph_bus_arbiter #(.NSLV(4), .BASE(32'h4000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] slv_mem [4] = '{32'h1000_0000, 32'h2000_0000, 32'hA5A5_0001, 32'h4000_0000};

    always_comb begin
        for (int k = 0; k < 4; k++) bus.s_rdata[k*32 +: 32] = slv_mem[k];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.s_cs[k] && bus.s_wr) slv_mem[k] <= bus.s_wdata;
        end
    end

    typedef struct {
        bit          mst;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  cs;
        logic        swr;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [136:0] all_outs();
        return {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata,
                bus.s_cs, bus.s_wr, bus.s_addr, bus.s_wdata};
    endfunction

    task automatic wait_any_ack(input string name, input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.m0_ack || bus.m1_ack) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            n = -1;
            $display("FAIL %s: no ack within %0d cycles", name, budget);
        end
    endtask

    task automatic drive(input bit m, input bit req, input bit wr, input logic [31:0] a,
                         input logic [31:0] d);
        if (m) begin
            bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d;
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [31:0] rd;
        drive(v.mst, 1'b1, v.wr, v.addr, v.wdata);
        @(negedge clk);
        chk($sformatf("vec%0d_access", i),
            {bus.s_cs, bus.s_wr, bus.s_addr, bus.s_wdata, bus.m0_ack, bus.m1_ack},
            {v.cs, v.swr, v.saddr, v.swdata, 2'b00});
        @(negedge clk);
        rd = v.mst ? bus.m1_rdata : bus.m0_rdata;
        chk($sformatf("vec%0d_ack", i),
            {bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err, bus.s_cs, rd},
            {(v.mst ? 2'b10 : 2'b01), (v.mst ? {v.err, 1'b0} : {1'b0, v.err}), 4'b0000, v.rdata});
        drive(v.mst, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rd = v.mst ? bus.m1_rdata : bus.m0_rdata;
        chk($sformatf("vec%0d_hold", i), {bus.m0_ack, bus.m1_ack, rd}, {2'b00, v.rdata});
    endtask

    initial begin
        int n;
        int acks;
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end

    initial begin
        int n;
        int acks;
        tbl[0] = '{0, 1, 32'h4000_0008, 32'h0000_00FF, 4'b0001, 1, 32'h008, 32'h0000_00FF, 0, 32'h2000_0000};
        tbl[1] = '{1, 0, 32'h4000_2004, 32'h0BAD_0001, 4'b0100, 0, 32'h004, 32'h0BAD_0001, 0, 32'hA5A5_0001};
        tbl[2] = '{0, 0, 32'h4000_4000, 32'h0BAD_0002, 4'b0000, 0, 32'h000, 32'h0000_0000, 1, 32'h0000_0000};
        tbl[3] = '{0, 0, 32'h4000_0ABC, 32'h0BAD_0003, 4'b0001, 0, 32'hABC, 32'h0BAD_0003, 0, 32'h0000_00FF};
        tbl[4] = '{0, 1, 32'h4000_1000, 32'h1234_5678, 4'b0010, 1, 32'h000, 32'h1234_5678, 0, 32'h0000_00FF};
        tbl[5] = '{0, 0, 32'h4000_1FFF, 32'h0000_0000, 4'b0010, 0, 32'hFFF, 32'h0000_0000, 0, 32'h1234_5678};
        tbl[6] = '{1, 1, 32'h4000_3FFC, 32'hDEAD_BEEF, 4'b1000, 1, 32'hFFC, 32'hDEAD_BEEF, 0, 32'hA5A5_0001};
        tbl[7] = '{1, 0, 32'h4000_3000, 32'h0000_0000, 4'b1000, 0, 32'h000, 32'h0000_0000, 0, 32'hDEAD_BEEF};
        tbl[8] = '{1, 1, 32'h4000_4000, 32'hFFFF_FFFF, 4'b0000, 0, 32'h000, 32'h0000_0000, 1, 32'h0000_0000};
        tbl[9] = '{1, 0, 32'h3FFF_F000, 32'h0000_0000, 4'b0000, 0, 32'h000, 32'h0000_0000, 1, 32'h0000_0000};

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held with random requests: everything stays at zero.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'($urandom), 1'($urandom), $urandom, $urandom);
            drive(1, 1'($urandom), 1'($urandom), 32'h4000_0000 | ($urandom & 32'h3FFF), $urandom);
            @(negedge clk);
            chk($sformatf("reset_outs%0d", i), 192'(all_outs()), 192'd0);
        end

        // Release with a simultaneous request: master 0 takes the first tie.
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h4000_1010, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4000_1010, 32'h0);
        wait_any_ack("tie_m0_wait", 6, n);
        chk("tie_m0_latency", 192'(n), 192'd2);
        chk("tie_m0_ack", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m0_rdata}, {3'b100, 32'h2000_0000});
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_any_ack("tie_m1_wait", 6, n);
        chk("tie_m1_spacing", 192'(n), 192'd3);
        chk("tie_m1_ack", {bus.m0_ack, bus.m1_ack, bus.m1_err, bus.m1_rdata}, {3'b010, 32'h2000_0000});
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

        // Both masters request continuously: grants alternate 0,1,... starting with 0.
        drive(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4000_2000, 32'h0);
        for (int i = 0; i < 6; i++) begin
            wait_any_ack($sformatf("fair%0d_wait", i), 6, n);
            chk($sformatf("fair%0d_spacing", i), 192'(n), (i == 0) ? 192'd2 : 192'd3);
            chk($sformatf("fair%0d_grant", i), {bus.m1_ack, bus.m0_ack},
                (i % 2) ? 2'b10 : 2'b01);
            chk($sformatf("fair%0d_rdata", i), (i % 2) ? bus.m1_rdata : bus.m0_rdata,
                (i % 2) ? 32'hA5A5_0001 : 32'h0000_00FF);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks += int'(bus.m0_ack) + int'(bus.m1_ack);
        end
        chk("fair_no_extra", 192'(acks), 192'd0);

        // Reset asserted during ACCESS: no ack, outputs cleared, request re-served afterwards.
        drive(1, 1'b1, 1'b0, 32'h4000_3000, 32'h0);
        @(negedge clk);
        chk("midrst_access", {bus.s_cs, bus.s_addr}, {4'b1000, 32'h0});
        rst = 1'b0;
        #1;
        chk("midrst_async", 192'(all_outs()), 192'd0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            acks += int'(bus.m0_ack) + int'(bus.m1_ack) + int'(|all_outs());
        end
        chk("midrst_quiet", 192'(acks), 192'd0);
        rst = 1'b1;
        wait_any_ack("midrst_reserve_wait", 6, n);
        chk("midrst_reserve_latency", 192'(n), 192'd2);
        chk("midrst_reserve_ack", {bus.m0_ack, bus.m1_ack, bus.m1_err, bus.m1_rdata},
            {3'b010, 32'hDEAD_BEEF});
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master, multi-slave arbiter for the peripheral register bus. It shares the single-cycle cs/wr/addr/wdata/rdata interface used by the GPIO block and the other memory-mapped peripherals between the CPU data port (master 0) and a second requester such as a DMA or debug port (master 1). It performs round-robin arbitration, address decode to one-hot slave selects, and a fixed-latency request/acknowledge handshake with registered read data and a decode-error flag.

## Interface
- NSLV, 4: number of slave windows; 1..8.
- BASE, 32'h4000_0000: peripheral region base; must be aligned to NSLV*4 KB.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- m0_req, m1_req  in  1  transaction request; hold high with fields stable until ack.
- m0_wr, m1_wr  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  valid with ack; 1 = address decode miss.
- m0_rdata, m1_rdata  out  32  read data, valid with ack; held until the next ack to that master.
- s_cs  out  NSLV  one-hot slave select, high for exactly one cycle per access.
- s_wr  out  1  write strobe, qualified by s_cs.
- s_addr  out  32  offset within the slave window: {20'b0, addr[11:0]}.
- s_wdata  out  32  write data.
- s_rdata  in  NSLV*32  slave read buses; slave k occupies bits [32k+31:32k]; combinational from s_addr.

## Operation
- Decode: hit when addr[31:12] - BASE[31:12] < NSLV. Slave index = addr[31:12] - BASE[31:12]. Otherwise it is a miss.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, pick a winner, latch its wr/addr/wdata and the master id, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration: a single requester wins. When both request, the master not granted last wins. The last_grant flop updates on every grant.
- ACCESS, one cycle:
  - On a hit, s_cs[idx]=1, and s_wr/s_addr/s_wdata are driven from the latched values.
  - The slave write occurs at the closing clock edge.
  - On a read hit, s_rdata[idx] is captured into the winner's rdata register at that edge. A write leaves rdata unchanged.
  - On a miss, s_cs stays 0, err is set, and rdata is loaded with 0.
  - Next state is DONE.
- DONE, one cycle: the winner's ack=1, with err valid. Next state is IDLE.
- The loser's req is ignored until the FSM returns to IDLE. No request is dropped.
- Requester rule: deassert req in the cycle after ack unless a new transaction is wanted. If req is still high in IDLE, it is treated as a new request.
- s_wr, s_addr and s_wdata are 0 whenever s_cs is all-zero.

## Timing
- Reset (rst=0, async) drives:
  - state to IDLE.
  - all s_cs, s_wr, s_addr, s_wdata to 0.
  - all ack and err to 0.
  - both rdata to 0.
  - last_grant to master 1, so master 0 wins the first tie.
- Reset mid-transaction aborts it: no ack is issued, and a write issued in that same cycle is not guaranteed.
- Latency: a req sampled high in IDLE at edge N gives s_cs high in cycle N..N+1 and ack high in cycle N+1..N+2. Total is 2 cycles from the sampling edge to the ack cycle.
- Throughput: one transaction per 3 cycles. With both masters continuously requesting, grants alternate 0,1,0,1.
- All outputs are registered. No combinational path exists from m*_req to s_cs or ack.
- The s_rdata → m*_rdata path is one cycle. The slave must return data combinationally within the ACCESS cycle.
- Simultaneous req rise in IDLE is resolved by last_grant only.
- A req that drops before grant is simply not served.

## Test plan
- Reset: hold rst=0 with random inputs. All outputs read 0. Release rst, assert m0_req and m1_req together. Master 0 is granted first and ack is seen at m0.
- Write hit: m0 writes 32'h0000_00FF to BASE+0x008. In the ACCESS cycle s_cs=4'b0001, s_wr=1, s_addr=32'h8, s_wdata=32'hFF. m0_ack follows one cycle later with m0_err=0.
- Read hit on slave 2: s_rdata slot 2 = 32'hA5A5_0001. m1 reads BASE+0x2004. s_cs=4'b0100 and s_addr=32'h4. m1_ack comes 2 cycles after sampling with m1_rdata=32'hA5A5_0001, which holds afterwards.
- Decode miss: m0 reads BASE+0x4000 with NSLV=4. s_cs stays 0 throughout. m0_ack=1, m0_err=1, m0_rdata=0.
- Fairness: both masters hold req for 6 transactions. Grant order is 0,1,0,1,0,1, with acks spaced exactly 3 cycles apart.
- Reset mid-op: assert rst=0 in the ACCESS cycle. No ack is issued, and all outputs are 0 during reset. After release, the pending req is re-served normally.
